// File: rtl/cache_tag_ctrl.sv
// Tag-side controller for the 4-way, 64-set cache: power-on invalidation sweep,
// lookup, tree-PLRU replacement, writeback/allocate handshake and tag/dirty update.
package cache_def;
  localparam int unsigned TAG_W   = 20;
  localparam int unsigned INDEX_W = 6;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [1:0]         way;
    logic               we;
  } cache_req_type;
endpackage

module cache_tag_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req_valid,
  input  logic                     cpu_req_rw,
  input  logic [ADDR_W-1:0]        cpu_req_addr,
  output logic                     cpu_req_ready,
  output logic                     cpu_resp_valid,
  output logic [1:0]               cpu_resp_way,
  output cache_def::cache_req_type tag_req,
  output cache_def::cache_tag_type tag_write,
  input  cache_def::cache_tag_type tag_read [4],
  output logic                     mem_req_valid,
  output logic                     mem_req_rw,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic                     mem_ack,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned SETS    = 1 << INDEX_W;
  localparam int unsigned SWEEP_W = INDEX_W + 2;
  localparam int unsigned LINE_W  = ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t                     state_q, state_d;
  logic [SWEEP_W-1:0]         sweep_q, sweep_d;
  logic                       req_rw_q;
  logic [LINE_W-1:0]          req_line_q;
  logic [1:0]                 victim_q, victim_d;
  logic                       recheck_q, recheck_d;
  logic [SETS-1:0][2:0]       plru_q, plru_d;
  logic [CNT_W-1:0]           hit_q, hit_d, miss_q, miss_d;
  logic                       mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
  logic                       accept_c;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic               hit;
  logic [1:0]         hit_way;
  logic               has_inv;
  logic [1:0]         inv_way;
  logic [2:0]         plru_cur;
  logic [1:0]         victim_c;
  logic               unused_offset;

  assign unused_offset = ^cpu_req_addr[OFFSET_W-1:0];
  assign req_tag  = req_line_q[LINE_W-1 -: TAG_W];
  assign req_idx  = req_line_q[INDEX_W-1:0];
  assign plru_cur = plru_q[req_idx];

  // Lookup of the latched set; descending scan so the lowest matching/invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    has_inv = 1'b0;
    inv_way = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (tag_read[w].valid && (tag_read[w].tag == req_tag)) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
      if (!tag_read[w].valid) begin
        has_inv = 1'b1;
        inv_way = 2'(w);
      end
    end
    if (has_inv)          victim_c = inv_way;
    else if (plru_cur[0]) victim_c = {1'b1, plru_cur[2]};
    else                  victim_c = {1'b0, plru_cur[1]};
  end

  assign cpu_req_ready = (state_q == S_IDLE);
  assign mem_req_valid = mem_valid_q;
  assign mem_req_rw    = mem_rw_q;
  assign mem_req_addr  = mem_addr_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

  // Next-state and tag-array / response sequencing.
  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    victim_d       = victim_q;
    recheck_d      = recheck_q;
    plru_d         = plru_q;
    hit_d          = hit_q;
    miss_d         = miss_q;
    mem_valid_d    = mem_valid_q;
    mem_rw_d       = mem_rw_q;
    mem_addr_d     = mem_addr_q;
    accept_c       = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_way   = 2'd0;
    tag_req        = '0;
    tag_write      = '0;

    unique case (state_q)
      S_INIT: begin
        // we is gated by rst_n so nothing is written while reset is held.
        tag_req.index = sweep_q[SWEEP_W-1:2];
        tag_req.way   = sweep_q[1:0];
        tag_req.we    = rst_n;
        sweep_d       = sweep_q + SWEEP_W'(1);
        if (sweep_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        mem_valid_d = 1'b0;
        if (cpu_req_valid) begin
          accept_c  = 1'b1;
          recheck_d = 1'b0;
          state_d   = S_COMPARE;
        end
      end
      S_COMPARE: begin
        tag_req.index = req_idx;
        if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_way   = hit_way;
          plru_d[req_idx][0] = ~hit_way[1];
          if (!hit_way[1]) plru_d[req_idx][1] = ~hit_way[0];
          else             plru_d[req_idx][2] = ~hit_way[0];
          if (req_rw_q) begin
            tag_req.way     = hit_way;
            tag_req.we      = 1'b1;
            tag_write.valid = 1'b1;
            tag_write.dirty = 1'b1;
            tag_write.tag   = req_tag;
          end
          if (!recheck_q && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
          state_d = S_IDLE;
        end else begin
          if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
          victim_d    = victim_c;
          mem_valid_d = 1'b1;
          if (tag_read[victim_c].valid && tag_read[victim_c].dirty) begin
            mem_rw_d   = 1'b1;
            mem_addr_d = {tag_read[victim_c].tag, req_idx, OFFSET_W'(0)};
            state_d    = S_WRITEBACK;
          end else begin
            mem_rw_d   = 1'b0;
            mem_addr_d = {req_line_q, OFFSET_W'(0)};
            state_d    = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        tag_req.index = req_idx;
        if (mem_ack) begin
          mem_rw_d   = 1'b0;
          mem_addr_d = {req_line_q, OFFSET_W'(0)};
          state_d    = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        tag_req.index = req_idx;
        if (mem_ack) begin
          tag_req.way     = victim_q;
          tag_req.we      = 1'b1;
          tag_write.valid = 1'b1;
          tag_write.dirty = 1'b0;
          tag_write.tag   = req_tag;
          mem_valid_d     = 1'b0;
          recheck_d       = 1'b1;
          state_d         = S_COMPARE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      req_rw_q    <= 1'b0;
      req_line_q  <= '0;
      victim_q    <= 2'd0;
      recheck_q   <= 1'b0;
      plru_q      <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      victim_q    <= victim_d;
      recheck_q   <= recheck_d;
      plru_q      <= plru_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      if (accept_c) begin
        req_rw_q   <= cpu_req_rw;
        req_line_q <= cpu_req_addr[ADDR_W-1:OFFSET_W];
      end
    end
  end
endmodule
